// File: rtl/flop_write_arbiter.sv
// -----------------------------------------------------------------------------
// flop_write_arbiter
//   Round-robin arbiter that schedules all writes into one shared register so
//   that exactly one load happens per clock edge. Each write is acknowledged
//   with a single-cycle one-hot grant pulse. A requester granted on one edge is
//   masked on the next edge. This lets it drop req after seeing gnt without
//   being granted twice.
//
// Parameters
//   size  width of the shared register and of each requester's data lane
//   nreq  number of requesters (2..8)
//   cntw  width of the saturating write counter
//
// Ports
//   clk      clock, all state changes on the rising edge
//   rst_n    asynchronous active-low reset
//   req      request vector, bit i belongs to requester i
//   wdata    packed write data, requester i = wdata[i*size +: size]
//   hold     freezes arbitration and register loading
//   gnt      registered one-hot grant pulse
//   q        shared register contents
//   q_valid  set once q has been written since reset
//   busy     high while the sequencer is in GRANT
//   wr_cnt   saturating count of completed writes
// -----------------------------------------------------------------------------
module flop_write_arbiter #(
  parameter int size = 4,
  parameter int nreq = 4,
  parameter int cntw = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [nreq-1:0]      req,
  input  logic [nreq*size-1:0] wdata,
  input  logic                 hold,
  output logic [nreq-1:0]      gnt,
  output logic [size-1:0]      q,
  output logic                 q_valid,
  output logic                 busy,
  output logic [cntw-1:0]      wr_cnt
);

  localparam int pw = (nreq > 1) ? $clog2(nreq) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  logic [1:0]      state, state_nxt;
  logic [pw-1:0]   ptr, ptr_nxt;
  logic [pw-1:0]   sel;
  logic            found;
  logic [nreq-1:0] elig;
  logic [nreq-1:0] sel_onehot;
  logic [size-1:0] sel_data;
  logic            do_write;

  // The registered grant doubles as the mask. Last edge's winner sits out
  // this edge.
  assign elig = req & ~gnt;

  // Rotating priority search. Scan from ptr upward and wrap modulo nreq.
  always_comb begin
    logic [pw:0]   idx;
    logic [pw-1:0] cand;
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path through the block leaves one unassigned and no latch is inferred.
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < nreq; k++) begin
      idx = {1'b0, ptr} + (pw+1)'(k);
      if (idx >= (pw+1)'(nreq)) idx = idx - (pw+1)'(nreq);
      cand = idx[pw-1:0];
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    sel_data   = '0;
    for (int k = 0; k < nreq; k++) begin
      if (sel == pw'(k)) begin
        sel_onehot[k] = 1'b1;
        sel_data      = wdata[k*size +: size];
      end
    end
  end

  // FROZEN never loads the register, even on the edge where hold drops.
  assign do_write = (state != ST_FROZEN) && !hold && found;

  assign ptr_nxt = (sel == pw'(nreq-1)) ? '0 : sel + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_GRANT: begin
        if (hold)       state_nxt = ST_FROZEN;
        else if (found) state_nxt = ST_GRANT;
        else            state_nxt = ST_IDLE;
      end
      ST_FROZEN: if (!hold) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      gnt     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (do_write) begin
        q       <= sel_data;
        gnt     <= sel_onehot;
        ptr     <= ptr_nxt;
        q_valid <= 1'b1;
        if (wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
      end else begin
        gnt <= '0;
      end
    end
  end

  assign busy = (state == ST_GRANT);

endmodule

// File: tb/tb_flop_write_arbiter.sv
module tb_flop_write_arbiter;

  localparam int SIZE = 4;
  localparam int NREQ = 4;

  typedef enum int {M_IDLE, M_GRANT, M_FROZEN} mstate_t;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [SIZE-1:0] q;
    logic            qv;
    logic            busy;
    logic [7:0]      cnt;
    logic [1:0]      cnt2;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] wdata;
  logic                 hold;
  logic [NREQ-1:0]      gnt;
  logic [SIZE-1:0]      q;
  logic                 q_valid;
  logic                 busy;
  logic [7:0]           wr_cnt;

  logic [NREQ-1:0]      gnt2;
  logic [SIZE-1:0]      q2;
  logic                 q_valid2;
  logic                 busy2;
  logic [1:0]           wr_cnt2;

  int n_cmp;
  int n_err;

  exp_t sb[$];

  // Reference model state
  logic [NREQ-1:0] m_gnt;
  logic [SIZE-1:0] m_q;
  logic            m_qv;
  int              m_ptr;
  int              m_cnt;
  mstate_t         m_state;

  flop_write_arbiter #(.size(SIZE), .nreq(NREQ), .cntw(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .hold(hold),
    .gnt(gnt), .q(q), .q_valid(q_valid), .busy(busy), .wr_cnt(wr_cnt)
  );

  // Narrow-counter instance, used to check saturation at 3.
  flop_write_arbiter #(.size(SIZE), .nreq(NREQ), .cntw(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .hold(hold),
    .gnt(gnt2), .q(q2), .q_valid(q_valid2), .busy(busy2), .wr_cnt(wr_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gnt   = '0;
    m_q     = '0;
    m_qv    = 1'b0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_state = M_IDLE;
  endtask

  // Model of one rising edge; returns the outputs expected right after it.
  task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ*SIZE-1:0] wd,
                            input logic h, output exp_t e);
    logic [NREQ-1:0] el;
    int              win;
    el  = r & ~m_gnt;
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (win < 0 && el[i]) win = i;
    end
    if (m_state != M_FROZEN && !h && win >= 0) begin
      m_q   = wd[win*SIZE +: SIZE];
      m_gnt = NREQ'(1) << win;
      m_ptr = (win + 1) % NREQ;
      m_qv  = 1'b1;
      m_cnt = m_cnt + 1;
    end else begin
      m_gnt = '0;
    end
    if (m_state == M_FROZEN) m_state = h ? M_FROZEN : M_IDLE;
    else if (h)              m_state = M_FROZEN;
    else if (win >= 0)       m_state = M_GRANT;
    else                     m_state = M_IDLE;
    e.gnt  = m_gnt;
    e.q    = m_q;
    e.qv   = m_qv;
    e.busy = (m_state == M_GRANT);
    e.cnt  = (m_cnt > 255) ? 8'hFF : 8'(m_cnt);
    e.cnt2 = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
  endtask

  // Drive one cycle of stimulus, push the expectation, then compare after the edge.
  task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ*SIZE-1:0] wd, input logic h);
    exp_t e;
    @(negedge clk);
    req   = r;
    wdata = wd;
    hold  = h;
    model_step(r, wd, h, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("gnt",     32'(gnt),     32'(e.gnt));
      check("q",       32'(q),       32'(e.q));
      check("q_valid", 32'(q_valid), 32'(e.qv));
      check("busy",    32'(busy),    32'(e.busy));
      check("wr_cnt",  32'(wr_cnt),  32'(e.cnt));
      check("wr_cnt2", 32'(wr_cnt2), 32'(e.cnt2));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    wdata = '0;
    hold  = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = '0;
    wdata = '0;
    hold  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt",    32'(gnt),     32'd0);
    check("rst_q",      32'(q),       32'd0);
    check("rst_qvalid", 32'(q_valid), 32'd0);
    check("rst_busy",   32'(busy),    32'd0);
    check("rst_wrcnt",  32'(wr_cnt),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (2) cycle(4'b0000, '0, 1'b0);

    // 2: single requester, granted every other cycle
    cycle(4'b0001, 16'h000A, 1'b0);
    check("t2_gnt", 32'(gnt), 32'h1);
    check("t2_q",   32'(q),   32'hA);
    check("t2_cnt", 32'(wr_cnt), 32'd1);
    cycle(4'b0001, 16'h000A, 1'b0);
    check("t2_gap", 32'(gnt), 32'h0);
    cycle(4'b0001, 16'h000A, 1'b0);
    check("t2_cnt2", 32'(wr_cnt), 32'd2);
    repeat (2) cycle(4'b0001, 16'h000A, 1'b0);
    repeat (2) cycle(4'b0000, 16'h000A, 1'b0);

    // 3: all requesting, back-to-back round robin from ptr 0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 16'h4321, 1'b0);
      check("t3_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
      check("t3_q",   32'(q),   32'((i % 4) + 1));
    end
    check("t3_sat2", 32'(wr_cnt2), 32'd3);
    check("t3_cnt",  32'(wr_cnt),  32'd8);
    cycle(4'b0000, 16'h4321, 1'b0);

    // 4: ptr=2 with req 0011 wraps to 0, then 1
    do_reset();
    cycle(4'b0010, 16'h00B0, 1'b0);
    cycle(4'b0000, 16'h00B0, 1'b0);
    cycle(4'b0011, 16'h00C5, 1'b0);
    check("t4_wrap", 32'(gnt), 32'h1);
    check("t4_q0",   32'(q),   32'h5);
    cycle(4'b0011, 16'h00C5, 1'b0);
    check("t4_next", 32'(gnt), 32'h2);
    check("t4_q1",   32'(q),   32'hC);
    cycle(4'b0000, 16'h00C5, 1'b0);
    cycle(4'b1111, 16'h9876, 1'b0);
    check("t4_ptr2", 32'(gnt), 32'h4);

    // 5: hold beats a pending request
    do_reset();
    cycle(4'b0100, 16'h0300, 1'b1);
    cycle(4'b0100, 16'h0300, 1'b1);
    check("t5_frz_gnt", 32'(gnt), 32'h0);
    check("t5_frz_q",   32'(q),   32'h0);
    cycle(4'b0100, 16'h0300, 1'b0);
    check("t5_idle_gnt", 32'(gnt), 32'h0);
    cycle(4'b0100, 16'h0300, 1'b0);
    check("t5_gnt", 32'(gnt), 32'h4);
    check("t5_q",   32'(q),   32'h3);
    cycle(4'b0000, 16'h0300, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      cycle(NREQ'($urandom_range(0, 15)), 16'($urandom),
            ($urandom_range(0, 6) == 0));
    end

    // 6: asynchronous reset in the middle of GRANT
    cycle(4'b1111, 16'hFEDC, 1'b0);
    cycle(4'b1111, 16'hFEDC, 1'b0);
    check("t6_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_gnt",    32'(gnt),     32'd0);
    check("t6_q",      32'(q),       32'd0);
    check("t6_qvalid", 32'(q_valid), 32'd0);
    check("t6_wrcnt",  32'(wr_cnt),  32'd0);
    check("t6_busy0",  32'(busy),    32'd0);
    req = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1000, 16'h7000, 1'b0);
    check("t6_after", 32'(gnt), 32'h8);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
